// File: rtl/ps2_host_rx.sv
// PS/2 host-side receiver. Synchronises and filters the keyboard clock/data pair,
// deframes 11-bit frames (start, 8 data LSB first, odd parity, stop), and buffers
// good bytes in a first-word-fall-through FIFO.
// Optional feature macro: PS2_RX_INHIBIT_EN -- hold ps2_clk low while the FIFO is
// full and the receiver is idle, so the keyboard holds keys back instead of them
// being dropped.
module ps2_host_rx #(
    parameter int FIFO_AW    = 3,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err,
    output logic       ps2_clk_inh
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- input synchronisers and clock filter ----------------
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic          fe;

    // Two-flop synchronisers; lines idle high so reset to 1.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else if (clk_s2_q == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q <= clk_s2_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    // Bit event: the cycle in which the filtered clock is about to fall.
    assign fe = filt_q & ~clk_s2_q & (fcnt_q == FW'(FILTER_LEN - 1));

    // ---------------- frame FSM ----------------
    state_t        state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    sr_q, sr_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          push_q, push_d;
    logic [7:0]    pbyte_q;
    logic          ferr_q, ferr_d;

    // Frame state and shift registers; the accepted byte is latched with the push.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
            tcnt_q  <= '0;
            push_q  <= 1'b0;
            pbyte_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            tcnt_q  <= tcnt_d;
            push_q  <= push_d;
            if (push_d) pbyte_q <= sr_q;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state: advance on bit events; abort the frame when the line stalls.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sr_d    = sr_q;
        par_d   = par_q;
        tcnt_d  = tcnt_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        if (fe) begin
            tcnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    // A high start bit is a false start; stay idle.
                    if (!dat_s2_q) begin
                        state_d = S_DATA;
                        bcnt_d  = '0;
                    end
                end
                S_DATA: begin
                    sr_d   = {dat_s2_q, sr_q[7:1]};
                    bcnt_d = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if ((^{sr_q, par_q}) && dat_s2_q) push_d = 1'b1;
                    else                               ferr_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
                state_d = S_IDLE;
                tcnt_d  = '0;
                ferr_d  = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    assign frame_err = ferr_q;

    // ---------------- FWFT FIFO ----------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               ovf_q;
    logic               full, pop, wr_en, drop;

    assign ready = (count_q != '0);
    assign full  = (count_q == DEPTH_C);
    assign pop   = rd & ready;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign wr_en = push_q & (~full | pop);
    assign drop  = push_q & full & ~pop;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk50) begin
        if (wr_en) mem[wr_ptr_q] <= pbyte_q;
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (pop)       ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
        end
    end

    assign data     = ready ? mem[rd_ptr_q] : 8'h00;
    assign overflow = ovf_q;

`ifdef PS2_RX_INHIBIT_EN
    assign ps2_clk_inh = full & (state_q == S_IDLE);
`else
    assign ps2_clk_inh = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_rx.sv
// Randomised bench for ps2_host_rx: frames are bit-banged on ps2_clk/ps2_data and
// the outputs are compared against a queue-based model of the received byte stream.
module tb_ps2_host_rx;

    localparam int TO = 600;   // shortened frame timeout for simulation
    localparam int HB = 32;    // half bit period in clk50 cycles

    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] dout;
    logic       ready, overflow, frame_err, ps2_clk_inh;

    ps2_host_rx #(.FIFO_AW(3), .FILTER_LEN(8), .TIMEOUT(TO)) dut (
        .clk50(clk50), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd(rd), .data(dout), .ready(ready), .overflow(overflow),
        .frame_err(frame_err), .ps2_clk_inh(ps2_clk_inh)
    );

    always #10 clk50 = ~clk50;

    int n_chk = 0;
    int n_err = 0;
    int err_cyc = 0;   // cycles with frame_err high (each error is a 1-cycle pulse)
    int exp_err = 0;
    logic [7:0] q[$];  // model FIFO contents
    logic       exp_ovf = 1'b0;

    always @(posedge clk50) if (frame_err) err_cyc <= err_cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk50);
    endtask

    function automatic logic exp_inh();
`ifdef PS2_RX_INHIBIT_EN
        return (q.size() == 8);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_state(input string tag);
        logic [7:0] hd;
        hd = (q.size() != 0) ? q[0] : 8'h00;
        check({tag, ".ready"}, 32'(ready), 32'(q.size() != 0));
        check({tag, ".data"}, 32'(dout), 32'(hd));
        check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ".ferr"}, 32'(err_cyc), 32'(exp_err));
        check({tag, ".inh"}, 32'(ps2_clk_inh), 32'(exp_inh()));
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            // short low glitch, then a short high glitch inside the real low phase
            cyc(HB/2 - 3); ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(1);
            ps2_clk = 1'b0; cyc(HB/2); ps2_clk = 1'b1; cyc(1); ps2_clk = 1'b0; cyc(1);
            ps2_clk = 1'b1; cyc(HB/2 - 2); ps2_clk = 1'b1; cyc(HB/2);
        end else begin
            cyc(HB/2); ps2_clk = 1'b0; cyc(HB); ps2_clk = 1'b1; cyc(HB/2);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit glitch);
        logic p;
        p = (~^b) ^ bad_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 3 || i == 6));
        send_bit(p, 1'b0);
        send_bit(stop, 1'b0);
        ps2_data = 1'b1;
        cyc(20);
        if (!bad_par && stop) begin
            if (q.size() == 8) exp_ovf = 1'b1;
            else               q.push_back(b);
        end else begin
            exp_err++;
        end
    endtask

    task automatic do_rd();
        rd = 1'b1; cyc(1); rd = 1'b0;
        if (q.size() != 0) begin
            void'(q.pop_front());
            exp_ovf = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc(3); reset = 1'b0;
        q.delete(); exp_ovf = 1'b0;
        cyc(2);
    endtask

    initial begin
        cyc(2);
        do_reset();
        check_state("reset");

        send_frame(8'h1C, 0, 1, 0);  check_state("good_1C");
        do_rd();                     check_state("rd_1C");
        do_rd();                     check_state("rd_empty");
        send_frame(8'h1C, 1, 1, 0);  check_state("bad_par");
        send_frame(8'h3A, 0, 0, 0);  check_state("bad_stop");

        // start bit plus four data bits, then the line stalls
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        ps2_data = 1'b1;
        cyc(TO + 50);
        exp_err++;
        check_state("timeout");
        send_frame(8'hF0, 0, 1, 0);  check_state("after_to");
        do_rd();

        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 0, 1, 0);
            check(("ovf_fill.inh"), 32'(ps2_clk_inh), 32'(exp_inh()));
        end
        check_state("full");
        do_rd();
        cyc(1);
        check_state("full_rd");
        for (int i = 0; i < 8; i++) begin do_rd(); check_state("drain"); end

        send_frame(8'hAA, 0, 1, 1);  check_state("glitch_AA");
        do_rd();

        // reset in the middle of a frame, then a normal frame
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        do_reset();
        ps2_clk = 1'b1; ps2_data = 1'b1;
        cyc(50);
        check_state("mid_reset");
        send_frame(8'h5A, 0, 1, 0);  check_state("post_reset");

        for (int k = 0; k < 25; k++) begin
            logic [7:0] b;
            bit bp, st, gl;
            int nrd;
            b  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 7) != 0);
            gl = ($urandom_range(0, 4) == 0);
            send_frame(b, bp, st, gl);
            check_state("rand_rx");
            nrd = $urandom_range(0, 2);
            for (int j = 0; j < nrd; j++) do_rd();
            cyc(1);
            check_state("rand_rd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
